pipe_mem_stage: RTL
===================

Name: pipe_mem_stage

Overview:
- Parametrised MEM stage of the 5-stage pipeline, between the EX/MEM and MEM/WB registers.
- Owns the data memory and performs word loads/stores with a configurable number of wait states.
- Raises a stall toward upstream stages while an access is in progress.
- Registers the ALU result, the load data and control into the MEM/WB outputs.

Parameters:
- DW, 32, datapath width in bits (must be 32 when SUBWORD_EN is defined).
- DEPTH, 128, data memory depth in words (power of two).
- WAIT_CYCLES, 0, extra cycles each load/store occupies the stage (0 = single-cycle access).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- xm_rd  in  5  destination register
- xm_alu_out  in  DW  ALU result / byte address
- xm_reg_write  in  1  register write enable
- xm_mem_read  in  1  load request
- xm_mem_write  in  1  store request
- xm_store_data  in  DW  store data
- xm_size  in  2  access size: 00 byte, 01 half, 10 word (SUBWORD_EN only)
- xm_unsigned  in  1  zero-extend load (SUBWORD_EN only)
- stall  out  1  hold EX/MEM and earlier stages
- mw_rd  out  5  registered destination
- mw_alu_out  out  DW  registered ALU result
- mw_mem_data  out  DW  registered load data
- mw_mem_to_reg  out  1  writeback selects mw_mem_data
- mw_reg_write  out  1  registered write enable

Behaviour:
- Reset (clk edge with rst=1): all mw_* outputs become 0, wait counter becomes 0, FSM goes to IDLE. DM contents are not reset.
- Reset mid-access aborts the access: no DM write occurs.
- Memory op: mem_op = xm_mem_read | xm_mem_write.
  - If both are asserted, the store wins and the access is treated as a store (mw_mem_to_reg=0).
- Addressing: word index = xm_alu_out[log2(DEPTH)+1:2]. Higher bits are ignored (wrap modulo DEPTH). Bits [1:0] are ignored without SUBWORD_EN.
- Non-memory op: mw_* loads xm_* every cycle (1-cycle latency). mw_mem_to_reg=0; mw_mem_data holds its previous value.
- Wait counter cnt: width is clog2(WAIT_CYCLES+1), minimum 1 bit.
- stall is combinational: stall = mem_op & (cnt != WAIT_CYCLES).
  - WAIT_CYCLES=0 means stall is never asserted.
- FSM states:
  - IDLE (cnt=0): on mem_op with WAIT_CYCLES>0 → WAIT, cnt<=1.
  - WAIT: cnt increments each edge while stall=1.
  - Completion cycle: stall=0 with mem_op, i.e. cnt==WAIT_CYCLES.
- While stall=1:
  - mw_reg_write<=0, mw_rd<=0, mw_mem_to_reg<=0 (bubble).
  - No DM write.
  - Upstream must hold all xm_* inputs stable.
- Completion edge:
  - Store: DM[index]<=xm_store_data.
  - Load: mw_mem_data<=DM[index], mw_mem_to_reg<=1.
  - mw_rd, mw_alu_out and mw_reg_write load from xm_*.
  - cnt<=0, FSM → IDLE.
- Total stage occupancy of a memory op: WAIT_CYCLES+1 cycles. Back-to-back memory ops each pay the full wait.
- A store followed by a load to the same address: the load returns the stored data (write committed at the earlier edge).

Optional Feature:
- Macro SUBWORD_EN.
- Defined:
  - xm_size selects byte/half/word lanes, little-endian; byte lane = addr[1:0], half lane = addr[1].
  - Stores perform a read-modify-write of only the selected lanes.
  - Loads extract the selected lane: sign-extended, or zero-extended when xm_unsigned=1.
  - Misaligned half (addr[0]=1) or word (addr[1:0]!=0) accesses ignore the offending low bits.
- Not defined: xm_size and xm_unsigned are ignored; every access is a full word.

Test Plan:
1. WAIT_CYCLES=0: rst 2 cycles, then ALU op rd=5, alu_out=0x1234, reg_write=1 → next edge mw_rd=5, mw_alu_out=0x1234, mw_reg_write=1, mw_mem_to_reg=0, stall=0 throughout.
2. WAIT_CYCLES=0: store 0xDEADBEEF to addr 0x10, then load rd=3 from 0x10 → mw_mem_data=0xDEADBEEF, mw_mem_to_reg=1, mw_rd=3 one edge after the load.
3. WAIT_CYCLES=2: load from 0x10 held stable → stall=1 for exactly 2 cycles with mw_reg_write=0, then data registered on the 3rd edge; stall=0 afterward.
4. WAIT_CYCLES=2: assert rst during the 2nd stall cycle of a store of 0x55 to 0x20 → outputs 0, cnt=0, later load of 0x20 returns the old value.
5. DEPTH=128: store 0xA5A5A5A5 to addr 0x200, load from addr 0x000 → 0xA5A5A5A5 (address wrap).
6. SUBWORD_EN: word 0x000080FF at addr 0x40; LB from 0x40 → 0xFFFFFFFF; LBU from 0x41 → 0x00000080; SB of 0x11 to 0x42, then LW from 0x40 → 0x001180FF.

Source files
------------

// File: rtl/pipe_mem_stage.sv
// MEM stage: data memory with configurable wait states, upstream stall and MEM/WB register.
// Optional SUBWORD_EN macro enables byte/half lanes with sign/zero-extended loads.
module pipe_mem_stage #(
    parameter int DW          = 32,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    xm_rd,
    input  logic [DW-1:0] xm_alu_out,
    input  logic          xm_reg_write,
    input  logic          xm_mem_read,
    input  logic          xm_mem_write,
    input  logic [DW-1:0] xm_store_data,
    input  logic [1:0]    xm_size,
    input  logic          xm_unsigned,
    output logic          stall,
    output logic [4:0]    mw_rd,
    output logic [DW-1:0] mw_alu_out,
    output logic [DW-1:0] mw_mem_data,
    output logic          mw_mem_to_reg,
    output logic          mw_reg_write
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;

    logic          mem_op;
    logic          is_store;
    logic          is_load;
    logic          complete;
    logic [AW-1:0] idx;
    logic [DW-1:0] rd_word;
    logic [DW-1:0] wr_word;
    logic [DW-1:0] load_data;

    logic [DW-1:0] dm [DEPTH];

    // A simultaneous read+write request is handled as a store.
    assign mem_op   = xm_mem_read | xm_mem_write;
    assign is_store = xm_mem_write;
    assign is_load  = xm_mem_read & ~xm_mem_write;

    assign stall    = mem_op & (cnt != CNT_LAST);
    assign complete = mem_op & ~stall;

    assign idx      = xm_alu_out[AW+1:2];
    assign rd_word  = dm[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (stall) begin
                    state_next = S_WAIT;
                    cnt_next   = CW'(1);
                end
            end
            S_WAIT: begin
                // Dropping the request mid-access also falls back to idle.
                if (stall) begin
                    cnt_next = cnt + CW'(1);
                end else begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef SUBWORD_EN
    logic [1:0]    off;
    logic [7:0]    byte_val;
    logic [15:0]   half_val;
    logic [DW-1:0] lane_mask;
    logic [DW-1:0] lane_data;

    assign off = xm_alu_out[1:0];

    always_comb begin
        byte_val  = rd_word[{off, 3'b000} +: 8];
        half_val  = rd_word[{off[1], 4'b0000} +: 16];
        load_data = rd_word;
        lane_mask = '1;
        lane_data = xm_store_data;
        case (xm_size)
            2'b00: begin
                load_data = xm_unsigned ? {24'h000000, byte_val}
                                        : {{24{byte_val[7]}}, byte_val};
                lane_mask = 32'h0000_00FF << {off, 3'b000};
                lane_data = {4{xm_store_data[7:0]}};
            end
            2'b01: begin
                load_data = xm_unsigned ? {16'h0000, half_val}
                                        : {{16{half_val[15]}}, half_val};
                lane_mask = 32'h0000_FFFF << {off[1], 4'b0000};
                lane_data = {2{xm_store_data[15:0]}};
            end
            default: begin
                load_data = rd_word;
                lane_mask = '1;
                lane_data = xm_store_data;
            end
        endcase
        // Read-modify-write keeps the untouched lanes of the addressed word.
        wr_word = (rd_word & ~lane_mask) | (lane_data & lane_mask);
    end
`else
    logic unused_subword;

    assign unused_subword = ^{xm_size, xm_unsigned};
    assign load_data      = rd_word;
    assign wr_word        = xm_store_data;
`endif

    always_ff @(posedge clk) begin
        if (!rst && complete && is_store) begin
            dm[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mw_rd         <= '0;
            mw_alu_out    <= '0;
            mw_mem_data   <= '0;
            mw_mem_to_reg <= 1'b0;
            mw_reg_write  <= 1'b0;
        end else if (stall) begin
            mw_rd         <= '0;
            mw_mem_to_reg <= 1'b0;
            mw_reg_write  <= 1'b0;
        end else begin
            mw_rd         <= xm_rd;
            mw_alu_out    <= xm_alu_out;
            mw_reg_write  <= xm_reg_write;
            mw_mem_to_reg <= is_load;
            if (is_load) begin
                mw_mem_data <= load_data;
            end
        end
    end

endmodule
